// File: rtl/tpu_pkg.sv
// Shared TPU types: opcodes, sequencer state encoding and default widths.
// Also imported by control_unit so that both sides decode opcodes the same way.
package tpu_pkg;

    localparam int unsigned DEF_IMEM_DEPTH = 8;
    localparam int unsigned DEF_INSTR_W    = 16;
    localparam int unsigned DEF_ARRAY_N    = 2;
    localparam int unsigned OPCODE_W       = 3;
    localparam int unsigned STATE_W        = 3;

    typedef enum logic [OPCODE_W-1:0] {
        OP_END     = 3'b000,
        OP_LOAD_W  = 3'b001,
        OP_LOAD_A  = 3'b010,
        OP_STORE   = 3'b011,
        OP_COMPUTE = 3'b100,
        OP_SYNC    = 3'b101,
        OP_ILL6    = 3'b110,
        OP_ILL7    = 3'b111
    } opcode_t;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE         = 3'd0;
    localparam state_t ST_FETCH        = 3'd1;
    localparam state_t ST_EXECUTE      = 3'd2;
    localparam state_t ST_COMPUTE_WAIT = 3'd3;
    localparam state_t ST_FINISH       = 3'd4;

    // END is consumed by the sequencer itself and illegal opcodes never reach control_unit.
    function automatic logic op_presented(input opcode_t op);
        return !(op == OP_END || op == OP_ILL6 || op == OP_ILL7);
    endfunction

endpackage

// File: rtl/tpu_sequencer_if.sv
// Program-load, control and instruction-issue signals of the TPU sequencer.
// The master side is the host/loader; the slave side is the sequencer.
interface tpu_sequencer_if #(
    parameter int unsigned IMEM_DEPTH = 8,
    parameter int unsigned INSTR_W    = 16
);
    localparam int unsigned ADDR_W = $clog2(IMEM_DEPTH);

    logic               start;
    logic               stall;
    logic               prog_we;
    logic [ADDR_W-1:0]  prog_addr;
    logic [INSTR_W-1:0] prog_data;
    logic [INSTR_W-1:0] instruction;
    logic               instr_valid;
    logic [ADDR_W-1:0]  pc;
    logic               busy;
    logic               done;
    logic               error;

    modport master (
        output start, stall, prog_we, prog_addr, prog_data,
        input  instruction, instr_valid, pc, busy, done, error
    );

    modport slave (
        input  start, stall, prog_we, prog_addr, prog_data,
        output instruction, instr_valid, pc, busy, done, error
    );

endinterface

// File: rtl/instr_mem.sv
// Instruction store: synchronous write, combinational read, contents survive reset.
module instr_mem #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 16,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_c
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_c = mem_q[raddr_i];

endmodule

// File: rtl/tpu_sequencer.sv
// Fetches instructions from instr_mem and issues them to control_unit, holding
// COMPUTE for COMPUTE_CYCLES unstalled cycles and stopping on END, an illegal opcode or the last slot.
module tpu_sequencer
    import tpu_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH     = DEF_IMEM_DEPTH,
    parameter int unsigned INSTR_W        = DEF_INSTR_W,
    parameter int unsigned ARRAY_N        = DEF_ARRAY_N,
    parameter int unsigned COMPUTE_CYCLES = 3 * ARRAY_N
) (
    input  logic            clk,
    input  logic            reset,
    tpu_sequencer_if.slave  bus
);

    localparam int unsigned ADDR_W = $clog2(IMEM_DEPTH);
    localparam int unsigned CNT_W  = $clog2(COMPUTE_CYCLES + 1);
    localparam logic [ADDR_W-1:0] PC_LAST  = ADDR_W'(IMEM_DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(COMPUTE_CYCLES - 1);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    logic               imem_we_c;
    logic [INSTR_W-1:0] imem_rdata_c;
    opcode_t            fetch_op_c;
    opcode_t            exec_op_c;
    logic               retire_c;
    logic               halt_c;

    instr_mem #(
        .DEPTH (IMEM_DEPTH),
        .WIDTH (INSTR_W)
    ) u_instr_mem (
        .clk     (clk),
        .we_i    (imem_we_c),
        .waddr_i (bus.prog_addr),
        .wdata_i (bus.prog_data),
        .raddr_i (pc_q),
        .rdata_c (imem_rdata_c)
    );

    assign fetch_op_c = opcode_t'(imem_rdata_c[INSTR_W-1 -: OPCODE_W]);
    assign exec_op_c  = opcode_t'(instr_q[INSTR_W-1 -: OPCODE_W]);

    // Writes are only accepted while the program is not running.
    assign imem_we_c = bus.prog_we && (state_q == ST_IDLE || state_q == ST_FINISH);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        error_d  = error_q;
        retire_c = 1'b0;
        halt_c   = 1'b0;

        if (!bus.stall) begin
            case (state_q)
                ST_IDLE, ST_FINISH: begin
                    if (bus.start) begin
                        state_d = ST_FETCH;
                        pc_d    = '0;
                        error_d = 1'b0;
                        busy_d  = 1'b1;
                    end
                end
                ST_FETCH: begin
                    state_d = ST_EXECUTE;
                    instr_d = imem_rdata_c;
                    valid_d = op_presented(fetch_op_c);
                end
                ST_EXECUTE: begin
                    case (exec_op_c)
                        OP_END: halt_c = 1'b1;
                        OP_ILL6, OP_ILL7: begin
                            halt_c  = 1'b1;
                            error_d = 1'b1;
                        end
                        OP_COMPUTE: begin
                            // EXECUTE is the first of the COMPUTE_CYCLES hold cycles.
                            if (COMPUTE_CYCLES > 1) begin
                                state_d = ST_COMPUTE_WAIT;
                                cnt_d   = CNT_W'(1);
                            end else begin
                                retire_c = 1'b1;
                            end
                        end
                        default: retire_c = 1'b1;
                    endcase
                end
                ST_COMPUTE_WAIT: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d    = '0;
                        retire_c = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // The last slot never wraps: completing it ends the program.
            if (retire_c) begin
                if (pc_q == PC_LAST) begin
                    halt_c = 1'b1;
                end else begin
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = ST_FETCH;
                    instr_d = '0;
                    valid_d = 1'b0;
                end
            end

            if (halt_c) begin
                state_d = ST_FINISH;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                instr_d = '0;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    // A stalled cycle presents nothing to control_unit.
    assign bus.instruction = instr_q;
    assign bus.instr_valid = valid_q & ~bus.stall;
    assign bus.pc          = pc_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.error       = error_q;

endmodule

// File: tb/tb_tpu_sequencer.sv
// Directed bench for tpu_sequencer: program trace, stall, illegal opcode,
// last-slot stop, reset abort and program-write gating.
module tb_tpu_sequencer;
    import tpu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tpu_sequencer_if #(.IMEM_DEPTH(8), .INSTR_W(16)) bus ();
    tpu_sequencer_if #(.IMEM_DEPTH(4), .INSTR_W(16)) bus4 ();

    tpu_sequencer #(.IMEM_DEPTH(8), .INSTR_W(16), .ARRAY_N(2)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    tpu_sequencer #(.IMEM_DEPTH(4), .INSTR_W(16), .ARRAY_N(2)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] prog_a [8]  = '{16'h200F, 16'h4000, 16'h201E, 16'h6000,
                                 16'h8000, 16'h2007, 16'hA000, 16'h0000};
    logic [15:0] exp_a  [12] = '{16'h200F, 16'h4000, 16'h201E, 16'h6000,
                                 16'h8000, 16'h8000, 16'h8000, 16'h8000,
                                 16'h8000, 16'h8000, 16'h2007, 16'hA000};

    logic [15:0] vals_q [$];
    int          done_idx;
    int          n_valid;
    int          n_8000;
    logic [2:0]  pc_at_done;
    logic        err_at_done;
    logic        busy_at_done;
    logic        err_at0;

    task automatic write_word(input logic [2:0] addr, input logic [15:0] data);
        @(negedge clk);
        bus.prog_we   = 1'b1;
        bus.prog_addr = addr;
        bus.prog_data = data;
        @(negedge clk);
        bus.prog_we   = 1'b0;
    endtask

    task automatic load_prog_a();
        for (int i = 0; i < 8; i++) write_word(3'(i), prog_a[i]);
    endtask

    // Leaves the bench at the sample point of the first FETCH cycle.
    task automatic do_start(input logic with_we, input logic [2:0] addr, input logic [15:0] data);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.prog_we   = with_we;
        bus.prog_addr = addr;
        bus.prog_data = data;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.prog_we = 1'b0;
    endtask

    task automatic capture(input int stall_from, input int stall_len, input int we_at,
                           input logic [2:0] we_addr, input logic [15:0] we_data, input int start_at);
        vals_q.delete();
        done_idx = -1;
        n_valid  = 0;
        n_8000   = 0;
        for (int i = 0; i < 60; i++) begin
            if (i > 0) @(negedge clk);
            bus.stall     = (i >= stall_from) && (i < stall_from + stall_len);
            bus.prog_we   = (i == we_at);
            bus.prog_addr = we_addr;
            bus.prog_data = we_data;
            bus.start     = (i == start_at);
            #1;
            if (i == 0) begin
                err_at0 = bus.error;
                n_checks++;
                if (bus.instr_valid !== 1'b0 || bus.instruction !== 16'h0 || bus.busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL fetch_cycle: valid=%b instr=%h busy=%b, expected 0/0000/1",
                             bus.instr_valid, bus.instruction, bus.busy);
                end
            end
            if (bus.instr_valid === 1'b1) begin
                vals_q.push_back(bus.instruction);
                n_valid++;
            end
            if (bus.instruction === 16'h8000) n_8000++;
            if (bus.done === 1'b1) begin
                done_idx     = i;
                pc_at_done   = bus.pc;
                err_at_done  = bus.error;
                busy_at_done = bus.busy;
                break;
            end
        end
        bus.stall   = 1'b0;
        bus.prog_we = 1'b0;
        bus.start   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if ({bus.instruction, bus.instr_valid, bus.pc, bus.busy, bus.done, bus.error} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: instr=%h valid=%b pc=%0d busy=%b done=%b err=%b, expected all 0",
                     bus.instruction, bus.instr_valid, bus.pc, bus.busy, bus.done, bus.error);
        end
        n_checks++;
        if ({bus4.instr_valid, bus4.pc, bus4.busy, bus4.done, bus4.error} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs4: valid=%b pc=%0d busy=%b, expected 0",
                     bus4.instr_valid, bus4.pc, bus4.busy);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b valid=%b, expected 0/0", bus.busy, bus.instr_valid);
        end
    endtask

    task automatic check_trace(input string name, input logic [15:0] word1);
        logic bad;
        logic [15:0] e;
        bad = 1'b0;
        n_checks++;
        if (vals_q.size() != 12) bad = 1'b1;
        else for (int k = 0; k < 12; k++) begin
            e = (k == 1) ? word1 : exp_a[k];
            if (vals_q[k] !== e) bad = 1'b1;
        end
        if (bad) begin
            n_fail++;
            $display("FAIL %s: got %0d valid words (first %h, second %h), expected 12 (200f, %h)",
                     name, vals_q.size(), (vals_q.size() > 0) ? vals_q[0] : 16'hxxxx,
                     (vals_q.size() > 1) ? vals_q[1] : 16'hxxxx, word1);
        end
        n_checks++;
        if (done_idx != 21) begin
            n_fail++;
            $display("FAIL %s_done_cycle: got %0d, expected 21", name, done_idx);
        end
    endtask

    task automatic test_program();
        load_prog_a();
        do_start(1'b0, 3'd0, 16'h0);
        capture(-1, 0, -1, 3'd0, 16'h0, -1);
        check_trace("program_trace", 16'h4000);
        n_checks++;
        if (pc_at_done !== 3'd7 || err_at_done !== 1'b0 || busy_at_done !== 1'b0) begin
            n_fail++;
            $display("FAIL program_finish: pc=%0d err=%b busy=%b, expected 7/0/0",
                     pc_at_done, err_at_done, busy_at_done);
        end
        @(negedge clk); #1;
        n_checks++;
        if (bus.done !== 1'b0 || bus.pc !== 3'd7) begin
            n_fail++;
            $display("FAIL done_pulse: done=%b pc=%0d a cycle later, expected 0/7", bus.done, bus.pc);
        end
    endtask

    task automatic test_stall();
        write_word(3'd0, 16'h8000);
        write_word(3'd1, 16'h0000);
        do_start(1'b0, 3'd0, 16'h0);
        capture(3, 3, -1, 3'd0, 16'h0, -1);
        n_checks++;
        if (n_valid != 6) begin
            n_fail++;
            $display("FAIL stall_valid_cycles: got %0d, expected 6", n_valid);
        end
        n_checks++;
        if (n_8000 != 9) begin
            n_fail++;
            $display("FAIL stall_hold_cycles: got %0d, expected 9", n_8000);
        end
        n_checks++;
        if (done_idx != 12) begin
            n_fail++;
            $display("FAIL stall_done_cycle: got %0d, expected 12", done_idx);
        end
    endtask

    task automatic test_illegal();
        write_word(3'd0, 16'h2000);
        write_word(3'd1, 16'h2000);
        write_word(3'd2, 16'hE000);
        do_start(1'b0, 3'd0, 16'h0);
        capture(-1, 0, -1, 3'd0, 16'h0, -1);
        n_checks++;
        if (done_idx != 6 || err_at_done !== 1'b1 || pc_at_done !== 3'd2 || n_valid != 2) begin
            n_fail++;
            $display("FAIL illegal_stop: done_at=%0d err=%b pc=%0d valids=%0d, expected 6/1/2/2",
                     done_idx, err_at_done, pc_at_done, n_valid);
        end
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (bus.error !== 1'b1 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL error_sticky: err=%b done=%b, expected 1/0", bus.error, bus.done);
        end
        do_start(1'b0, 3'd0, 16'h0);
        capture(-1, 0, -1, 3'd0, 16'h0, -1);
        n_checks++;
        if (err_at0 !== 1'b0) begin
            n_fail++;
            $display("FAIL error_cleared_by_start: err=%b, expected 0", err_at0);
        end
        n_checks++;
        if (done_idx != 6 || err_at_done !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_rerun: done_at=%0d err=%b, expected 6/1", done_idx, err_at_done);
        end
    endtask

    task automatic test_no_end();
        int d4;
        int v4;
        logic [1:0] pc4;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus4.prog_we   = 1'b1;
            bus4.prog_addr = 2'(i);
            bus4.prog_data = 16'h2000;
        end
        @(negedge clk);
        bus4.prog_we = 1'b0;
        bus4.start   = 1'b1;
        d4 = -1;
        v4 = 0;
        pc4 = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            bus4.start = 1'b0;
            #1;
            if (bus4.instr_valid === 1'b1) v4++;
            if (bus4.done === 1'b1) begin
                d4  = i;
                pc4 = bus4.pc;
                break;
            end
        end
        n_checks++;
        if (d4 != 8 || v4 != 4 || pc4 !== 2'd3) begin
            n_fail++;
            $display("FAIL no_end_stop: done_at=%0d valids=%0d pc=%0d, expected 8/4/3", d4, v4, pc4);
        end
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (bus4.pc !== 2'd3 || bus4.busy !== 1'b0 || bus4.instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL no_wrap: pc=%0d busy=%b valid=%b, expected 3/0/0",
                     bus4.pc, bus4.busy, bus4.instr_valid);
        end
    endtask

    task automatic test_reset_mid_compute();
        logic bad;
        load_prog_a();
        do_start(1'b0, 3'd0, 16'h0);
        for (int i = 0; i < 11; i++) @(negedge clk);
        #1;
        n_checks++;
        if (bus.instr_valid !== 1'b1 || bus.instruction !== 16'h8000) begin
            n_fail++;
            $display("FAIL third_compute_cycle: valid=%b instr=%h, expected 1/8000",
                     bus.instr_valid, bus.instruction);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({bus.instruction, bus.instr_valid, bus.pc, bus.busy, bus.done, bus.error} !== '0) begin
            n_fail++;
            $display("FAIL reset_abort: instr=%h valid=%b pc=%0d busy=%b done=%b err=%b, expected all 0",
                     bus.instruction, bus.instr_valid, bus.pc, bus.busy, bus.done, bus.error);
        end
        @(negedge clk);
        reset = 1'b1;
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk); #1;
            if (bus.instr_valid !== 1'b0 || bus.busy !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL no_resume_after_reset: valid=%b busy=%b, expected 0/0", bus.instr_valid, bus.busy);
        end
        do_start(1'b0, 3'd0, 16'h0);
        capture(-1, 0, -1, 3'd0, 16'h0, -1);
        check_trace("rerun_trace", 16'h4000);
    endtask

    task automatic test_prog_gating();
        do_start(1'b0, 3'd0, 16'h0);
        capture(-1, 0, 0, 3'd1, 16'hA0A0, 5);
        check_trace("busy_write_ignored", 16'h4000);
        do_start(1'b1, 3'd1, 16'hA0A0);
        capture(-1, 0, -1, 3'd0, 16'h0, -1);
        check_trace("finish_write_start", 16'hA0A0);
    endtask

    initial begin
        bus.start = 1'b0;  bus.stall = 1'b0;  bus.prog_we = 1'b0;
        bus.prog_addr = '0; bus.prog_data = '0;
        bus4.start = 1'b0; bus4.stall = 1'b0; bus4.prog_we = 1'b0;
        bus4.prog_addr = '0; bus4.prog_data = '0;
        test_reset();
        test_program();
        test_stall();
        test_illegal();
        test_no_end();
        test_reset_mid_compute();
        test_prog_gating();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tpu_sequencer.md
TPU_SEQUENCER -- requirements
Module: tpu_sequencer

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 8, instruction memory entries (power of 2, >=2).
REQ-002 SHALL have parameter INSTR_W, default 16, instruction width; opcode is the top 3 bits.
REQ-003 SHALL have parameter ARRAY_N, default 2, systolic array dimension.
REQ-004 SHALL have parameter COMPUTE_CYCLES, default 3*ARRAY_N, which is the number of cycles a COMPUTE instruction is held.
REQ-005 SHALL have ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  pulse; begins execution at pc 0 from IDLE or FINISH.
- stall  input  1  freezes the sequencer while high.
- prog_we  input  1  instruction memory write enable.
- prog_addr  input  $clog2(IMEM_DEPTH)  write address.
- prog_data  input  INSTR_W  write data.
- instruction  output  INSTR_W  instruction presented to control_unit.
- instr_valid  output  1  instruction is live this cycle.
- pc  output  $clog2(IMEM_DEPTH)  current instruction pointer.
- busy  output  1  high in FETCH, EXECUTE and COMPUTE_WAIT.
- done  output  1  one-cycle pulse on entry to FINISH.
- error  output  1  sticky illegal-opcode flag.

Function
REQ-006 SHALL implement the states IDLE, FETCH, EXECUTE, COMPUTE_WAIT and FINISH.
REQ-007 IDLE or FINISH with start=1 SHALL clear pc and error and go to FETCH next cycle.
REQ-008 FETCH SHALL register imem[pc] into the instruction register and go to EXECUTE; instr_valid=0.
REQ-009 EXECUTE SHALL drive instruction=instruction register and instr_valid=1.
REQ-010 In EXECUTE, opcode 000 (END) SHALL go to FINISH with pc unchanged.
REQ-011 In EXECUTE, opcode 100 (COMPUTE) SHALL go to COMPUTE_WAIT, holding instruction and instr_valid=1 for exactly COMPUTE_CYCLES cycles total (EXECUTE included).
REQ-012 After the last COMPUTE cycle, the sequencer SHALL increment pc and go to FETCH.
REQ-013 Opcodes 001, 010, 011 and 101 SHALL each execute for one cycle, then pc+1 and FETCH.
REQ-014 Opcodes 110 and 111 SHALL set error, drive instr_valid=0 and go to FINISH.
REQ-015 A non-END instruction at pc=IMEM_DEPTH-1 SHALL complete, then go to FINISH without pc wrap; pc stays IMEM_DEPTH-1.
REQ-016 When outside EXECUTE and COMPUTE_WAIT, instruction SHALL be 0 and instr_valid=0.
REQ-017 stall=1 SHALL hold state, pc, counter and outputs, with instr_valid forced to 0; a stalled cycle SHALL NOT count toward COMPUTE_CYCLES.
REQ-018 prog_we SHALL write only in IDLE or FINISH; writes in other states SHALL be ignored.
REQ-019 When start and prog_we occur together, the write SHALL land first and execution SHALL see the new word.
REQ-020 start while busy SHALL be ignored.
REQ-021 done SHALL pulse once per FINISH entry, including error entry.

Reset
REQ-022 reset low SHALL immediately force: state IDLE, pc 0, counter 0, instruction 0, instr_valid 0, busy 0, done 0, error 0.
REQ-023 Instruction memory contents SHALL NOT be cleared by reset.
REQ-024 Reset asserted mid-COMPUTE SHALL abort with no further instr_valid until a new start.

Structure
REQ-025 Opcode enum, state_t enum and the default widths SHALL live in shared package tpu_pkg, for reuse by control_unit.
REQ-026 Instruction memory SHALL be a sub-module, instr_mem: synchronous write, combinational read, no reset.

Verification
REQ-027 Load the 8-word program 001_F, 010, 001_1E, 011, 100, 001_7, 101, 000, then start -> instr_valid sequence 1,1,1,1,6x100,1,1; END reached, done at the cycle after the END EXECUTE, pc=7.
REQ-028 COMPUTE with stall high for 3 cycles mid-hold -> instruction=0x8000 with instr_valid=1 on exactly 6 unstalled cycles; 9 cycles in EXECUTE/COMPUTE_WAIT total.
REQ-029 Opcode 111 at pc=2 -> error=1, done pulse, pc=2; a following start clears error.
REQ-030 No END in memory (IMEM_DEPTH=4, all 001) -> 4 valid instructions, FINISH, pc=3, no wrap.
REQ-031 reset low during the 3rd COMPUTE cycle -> all outputs 0 immediately; memory intact, and a rerun produces an identical trace.
REQ-032 prog_we to addr 1 while busy -> ignored; the same write in FINISH with start -> the new word executes.
